// File: rtl/tune_classifier.sv
// Tuning-state classifier: grades each new peak against the target bin, debounces the class
// and times out to IDLE. Define TUNE_HYST_EN to widen the tuned window by one bin while tuned.
module tune_classifier #(
    parameter int W       = 10,
    parameter int HOLD    = 3,
    parameter int TIMEOUT = 50000000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] peak,
    input  logic [W-1:0] target,
    input  logic [W-1:0] tolerance,
    input  logic [W-1:0] very_flat_thr,
    input  logic [W-1:0] very_sharp_thr,
    input  logic         new_dom_freq,
    output logic         veryFlat,
    output logic         justFlat,
    output logic         tuned,
    output logic         justSharp,
    output logic         verySharp,
    output logic [2:0]   state,
    output logic [W-1:0] abs_diff,
    output logic         changed
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] VF   = 3'd1;
    localparam logic [2:0] JF   = 3'd2;
    localparam logic [2:0] T    = 3'd3;
    localparam logic [2:0] JS   = 3'd4;
    localparam logic [2:0] VS   = 3'd5;

    localparam int             IW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [IW-1:0]  TIMEOUT_V  = IW'(TIMEOUT);
    localparam logic [IW-1:0]  TIMEOUT_M1 = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0]  ONE_IW     = IW'(1);
    localparam logic [4:0]     HOLD_V     = 5'(HOLD);

    logic [W-1:0]  diff;
    logic          isSharp;
    logic          inTuned;
    logic [2:0]    sampleClass;
    logic [2:0]    cand;
    logic [3:0]    cnt;
    logic [4:0]    cntInc;
    logic [4:0]    indicators;
    logic [IW-1:0] idleCnt;
    logic          commitNow;
    logic          timeoutHit;
    logic          stateLegal;

    // Absolute difference is taken with the larger operand first, so it never wraps.
    assign isSharp = (peak > target);
    assign diff    = (peak >= target) ? (peak - target) : (target - peak);

`ifdef TUNE_HYST_EN
    logic [W:0] tolWide;
    assign tolWide = {1'b0, tolerance} + {{W{1'b0}}, (state == T)};
    assign inTuned = ({1'b0, diff} <= tolWide);
`else
    assign inTuned = (diff <= tolerance);
`endif

    always_comb begin
        if (inTuned) begin
            sampleClass = T;
        end else if (!isSharp) begin
            sampleClass = (diff >= very_flat_thr) ? VF : JF;
        end else begin
            sampleClass = (diff >= very_sharp_thr) ? VS : JS;
        end
    end

    assign stateLegal = (state <= VS);
    assign cntInc     = {1'b0, cnt} + 5'd1;
    assign commitNow  = new_dom_freq && stateLegal && (sampleClass != state) &&
                        ((sampleClass == cand) ? (cntInc >= HOLD_V) : (HOLD_V == 5'd1));
    assign timeoutHit = (TIMEOUT != 0) && !new_dom_freq && (state != IDLE) &&
                        (idleCnt >= TIMEOUT_M1);

    assign veryFlat  = indicators[0];
    assign justFlat  = indicators[1];
    assign tuned     = indicators[2];
    assign justSharp = indicators[3];
    assign verySharp = indicators[4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idleCnt <= '0;
        end else if (new_dom_freq) begin
            idleCnt <= '0;
        end else if ((TIMEOUT != 0) && (idleCnt != TIMEOUT_V)) begin
            idleCnt <= idleCnt + ONE_IW;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            abs_diff <= '0;
        end else if (new_dom_freq) begin
            abs_diff <= diff;
        end
    end

    // A strobe always takes priority over the timeout; a sample matching the committed
    // state restarts the debounce so only consecutive disagreeing samples can commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            indicators <= '0;
            cand       <= IDLE;
            cnt        <= '0;
            changed    <= 1'b0;
        end else begin
            changed <= 1'b0;
            if (!stateLegal) begin
                state      <= IDLE;
                indicators <= '0;
                cand       <= IDLE;
                cnt        <= '0;
            end else if (commitNow) begin
                state      <= sampleClass;
                indicators <= 5'd1 << (sampleClass - 3'd1);
                cand       <= sampleClass;
                cnt        <= '0;
                changed    <= 1'b1;
            end else if (new_dom_freq) begin
                if (sampleClass == state) begin
                    cand <= sampleClass;
                    cnt  <= '0;
                end else if (sampleClass == cand) begin
                    cnt <= cntInc[3:0];
                end else begin
                    cand <= sampleClass;
                    cnt  <= 4'd1;
                end
            end else if (timeoutHit) begin
                state      <= IDLE;
                indicators <= '0;
                cand       <= IDLE;
                cnt        <= '0;
                changed    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tune_classifier.sv
// Self-checking bench for tune_classifier: directed scenarios followed by randomized
// sample bursts, all compared against a sample-history reference model.
module tb_tune_classifier;

    localparam int W       = 10;
    localparam int HOLD    = 3;
    localparam int TIMEOUT = 20;
    localparam int MAXV    = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] peak;
    logic [W-1:0] target;
    logic [W-1:0] tolerance;
    logic [W-1:0] veryFlatThr;
    logic [W-1:0] verySharpThr;
    logic         newDomFreq;
    logic         veryFlat;
    logic         justFlat;
    logic         tuned;
    logic         justSharp;
    logic         verySharp;
    logic [2:0]   state;
    logic [W-1:0] absDiff;
    logic         changed;

    int testCount = 0;
    int failCount = 0;

    // Reference model: committed class, recent samples since the last break, quiet cycles.
    int mState;
    int hist[$];
    int quiet;
    int expAbs;
    int expChanged;

    tune_classifier #(.W(W), .HOLD(HOLD), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .peak          (peak),
        .target        (target),
        .tolerance     (tolerance),
        .very_flat_thr (veryFlatThr),
        .very_sharp_thr(verySharpThr),
        .new_dom_freq  (newDomFreq),
        .veryFlat      (veryFlat),
        .justFlat      (justFlat),
        .tuned         (tuned),
        .justSharp     (justSharp),
        .verySharp     (verySharp),
        .state         (state),
        .abs_diff      (absDiff),
        .changed       (changed)
    );

    always #5 clk = ~clk;

    function automatic int classify(int p, int t, int tol, int vft, int vst, int cur);
        int d;
        int win;
        int hystBins;
        hystBins = 0;
`ifdef TUNE_HYST_EN
        hystBins = 1;
`endif
        d   = (p > t) ? p - t : t - p;
        win = (cur == 3) ? tol + hystBins : tol;
        if (d <= win) return 3;
        if (p < t) return (d >= vft) ? 1 : 2;
        return (d >= vst) ? 5 : 4;
    endfunction

    task automatic modelReset();
        mState     = 0;
        hist.delete();
        quiet      = 0;
        expAbs     = 0;
        expChanged = 0;
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic modelEdge();
        int c;
        int run;
        expChanged = 0;
        if (newDomFreq) begin
            quiet  = 0;
            expAbs = (peak > target) ? int'(peak) - int'(target) : int'(target) - int'(peak);
            c = classify(int'(peak), int'(target), int'(tolerance), int'(veryFlatThr),
                         int'(verySharpThr), mState);
            if (c == mState) begin
                hist.delete();
            end else begin
                hist.push_back(c);
                run = 0;
                for (int i = hist.size() - 1; i >= 0; i--) begin
                    if (hist[i] != c) break;
                    run++;
                end
                if (run >= HOLD) begin
                    mState     = c;
                    hist.delete();
                    expChanged = 1;
                end
            end
        end else begin
            if (quiet < TIMEOUT) quiet++;
            if (TIMEOUT > 0 && quiet == TIMEOUT && mState != 0) begin
                mState     = 0;
                hist.delete();
                expChanged = 1;
            end
        end
    endtask

    task automatic checkValue(string tag, logic [31:0] got, logic [31:0] want);
        testCount++;
        assert (got === want) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic checkOutput(string tag);
        logic [4:0] expInd;
        expInd = (mState == 0) ? 5'd0 : (5'd1 << (mState - 1));
        checkValue({tag, ".state"}, {29'd0, state}, mState);
        checkValue({tag, ".ind"}, {27'd0, verySharp, justSharp, tuned, justFlat, veryFlat},
                   {27'd0, expInd});
        checkValue({tag, ".absDiff"}, {22'd0, absDiff}, expAbs);
        checkValue({tag, ".changed"}, {31'd0, changed}, expChanged);
    endtask

    task automatic applyStimulus(string tag, logic strobe, int p, int t, int tol, int vft, int vst);
        newDomFreq   = strobe;
        peak         = W'(p);
        target       = W'(t);
        tolerance    = W'(tol);
        veryFlatThr  = W'(vft);
        verySharpThr = W'(vst);
        modelEdge();
        @(posedge clk);
        #1;
        newDomFreq = 1'b0;
        checkOutput(tag);
    endtask

    initial begin
        reset_n      = 1'b0;
        newDomFreq   = 1'b0;
        peak         = '0;
        target       = '0;
        tolerance    = '0;
        veryFlatThr  = '0;
        verySharpThr = '0;
        modelReset();
        #2;
        checkOutput("reset");
        #10;
        reset_n = 1'b1;

        // Three agreeing tuned samples commit T.
        applyStimulus("tuned1", 1'b1, 100, 100, 2, 30, 30);
        applyStimulus("tuned2", 1'b1, 100, 100, 2, 30, 30);
        checkValue("tuned2.noCommit", {31'd0, tuned}, 0);
        applyStimulus("tuned3", 1'b1, 100, 100, 2, 30, 30);
        checkValue("tuned3.tuned", {31'd0, tuned}, 1);
        checkValue("tuned3.changed", {31'd0, changed}, 1);
        applyStimulus("tunedIdle", 1'b0, 0, 0, 0, 0, 0);

        // Window edges near 0 and near the top of the bin range.
        applyStimulus("edgeLow", 1'b1, 0, 3, 5, 30, 30);
        checkValue("edgeLow.abs", {22'd0, absDiff}, 3);
        applyStimulus("edgeHigh", 1'b1, 1023, 1020, 10, 30, 30);
        checkValue("edgeHigh.state", {29'd0, state}, 3);

        // Interrupted flat run: commits only on the third consecutive VF.
        applyStimulus("flat1", 1'b1, 460, 500, 2, 30, 30);
        applyStimulus("flat2", 1'b1, 490, 500, 2, 30, 30);
        applyStimulus("flat3", 1'b1, 460, 500, 2, 30, 30);
        applyStimulus("flat4", 1'b1, 460, 500, 2, 30, 30);
        checkValue("flat4.state", {29'd0, state}, 3);
        applyStimulus("flat5", 1'b1, 460, 500, 2, 30, 30);
        checkValue("flat5.veryFlat", {31'd0, veryFlat}, 1);

        // Enter JS, then let it time out.
        for (int i = 0; i < 3; i++) applyStimulus("toJs", 1'b1, 510, 500, 2, 30, 30);
        checkValue("toJs.state", {29'd0, state}, 4);
        for (int i = 0; i < TIMEOUT; i++) applyStimulus("quiet", 1'b0, 0, 0, 0, 0, 0);
        checkValue("timeout.state", {29'd0, state}, 0);
        checkValue("timeout.changed", {31'd0, changed}, 1);
        applyStimulus("afterTimeout", 1'b0, 0, 0, 0, 0, 0);

        // A strobe on the timeout cycle keeps JS.
        for (int i = 0; i < 3; i++) applyStimulus("reJs", 1'b1, 510, 500, 2, 30, 30);
        for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus("quiet2", 1'b0, 0, 0, 0, 0, 0);
        applyStimulus("rescue", 1'b1, 510, 500, 2, 30, 30);
        checkValue("rescue.state", {29'd0, state}, 4);
        applyStimulus("rescueIdle", 1'b0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a debounce run.
        applyStimulus("deb1", 1'b1, 500, 500, 2, 30, 30);
        applyStimulus("deb2", 1'b1, 500, 500, 2, 30, 30);
        #4;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("asyncReset");
        #2;
        reset_n = 1'b1;
        applyStimulus("postReset", 1'b1, 500, 500, 2, 30, 30);
        checkValue("postReset.state", {29'd0, state}, 0);

        // Tuned-edge sample: held by hysteresis only when enabled.
        for (int i = 0; i < 3; i++) applyStimulus("hystT", 1'b1, 300, 300, 2, 30, 30);
        for (int i = 0; i < 3; i++) applyStimulus("hystEdge", 1'b1, 303, 300, 2, 30, 30);
`ifdef TUNE_HYST_EN
        checkValue("hystEdge.state", {29'd0, state}, 3);
`else
        checkValue("hystEdge.state", {29'd0, state}, 4);
`endif

        // Randomized bursts of similar samples, with occasional long quiet gaps.
        for (int blk = 0; blk < 60; blk++) begin
            int t;
            int tol;
            int vft;
            int vst;
            int base;
            t    = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4))
                                                 : MAXV - int'($urandom_range(0, 4)))
                                               : int'($urandom_range(0, MAXV));
            tol  = int'($urandom_range(0, 8));
            vft  = int'($urandom_range(5, 60));
            vst  = int'($urandom_range(5, 60));
            base = int'($urandom_range(0, 120)) - 60;
            for (int k = 0; k < 6; k++) begin
                int pk;
                pk = t + base + int'($urandom_range(0, 2)) - 1;
                if (pk < 0) pk = 0;
                if (pk > MAXV) pk = MAXV;
                applyStimulus("rand", ($urandom_range(0, 9) < 8), pk, t, tol, vft, vst);
            end
            if (blk % 15 == 14) begin
                for (int g = 0; g < TIMEOUT + 3; g++) applyStimulus("randGap", 1'b0, 0, 0, 0, 0, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
